// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite responder in front of a bank of 32-bit registers
//
// Purpose: terminates an AXI4-Lite master with a register file. Register 0 is a
// read-only ID; the rest are software read/write. Every register is driven flat
// on REG_OUT, and each committed decoded write emits a one-cycle WR_EN/WR_INDEX.
//
// Ports:
//   CLK, nRST                     clock (rising edge), asynchronous active-low reset
//   AW*, W*, B*                   AXI4-Lite write address / data / response channels
//   AR*, R*                       AXI4-Lite read address / data channels
//   REG_OUT[32*C_REG_COUNT]       register image, reg n at [32n+31:32n]
//   WR_EN, WR_INDEX               one-cycle pulse and index of each committed register write
module axi4_lite_slave_regfile #(
    parameter int          C_ADDR_WIDTH = 20,
    parameter int          C_REG_COUNT  = 16,
    parameter logic [31:0] C_ID_VALUE   = 32'h52460001,
    localparam int         C_IDX_BITS   = $clog2(C_REG_COUNT)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [31:0]               WDATA,
    input  logic [3:0]                WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [31:0]               RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [32*C_REG_COUNT-1:0] REG_OUT,
    output logic                      WR_EN,
    output logic [C_IDX_BITS-1:0]     WR_INDEX
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any address bit above the register index field selects nothing.
    function automatic logic addr_out_of_range(input logic [C_ADDR_WIDTH-1:0] addr);
        return (addr >> (2 + C_IDX_BITS)) != '0;
    endfunction

    // Held low through reset and set on the first clock after release, so the
    // READY outputs read 0 during reset and rise one edge later.
    logic                  ready_en;

    logic                  aw_full;
    logic [C_IDX_BITS-1:0] aw_idx;
    logic                  aw_oor;
    logic                  w_full;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;

    logic [31:0]           regs [C_REG_COUNT];

    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  commit;
    logic                  wr_hit;
    logic [C_IDX_BITS-1:0] ar_idx;
    logic                  ar_oor;

    assign AWREADY = ready_en && !aw_full && !BVALID;
    assign WREADY  = ready_en && !w_full  && !BVALID;
    assign ARREADY = ready_en && !RVALID;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;

    // One outstanding write: commit only once both halves are latched and the
    // previous response has been taken.
    assign commit = aw_full && w_full && !BVALID;
    assign wr_hit = commit && !aw_oor && (aw_idx != '0);

    assign ar_idx = ARADDR[2 +: C_IDX_BITS];
    assign ar_oor = addr_out_of_range(ARADDR);

    // Channel control and response registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            aw_oor   <= 1'b0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            WR_EN    <= 1'b0;
            WR_INDEX <= '0;
        end else begin
            ready_en <= 1'b1;
            WR_EN    <= 1'b0;

            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= AWADDR[2 +: C_IDX_BITS];
                aw_oor  <= addr_out_of_range(AWADDR);
            end

            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end

            if (commit) begin
                BVALID <= 1'b1;
                BRESP  <= aw_oor ? RESP_DECERR : RESP_OKAY;
                if (wr_hit) begin
                    WR_EN    <= 1'b1;
                    WR_INDEX <= aw_idx;
                end
            end

            // BVALID blocks AWREADY/WREADY, so a B handshake never coincides
            // with a new AW/W handshake on the same edge.
            if (b_hs) begin
                BVALID  <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end

            // regs[] is sampled before this edge's write lands, so a read that
            // collides with a commit returns the old value.
            if (ar_hs) begin
                RVALID <= 1'b1;
                RDATA  <= ar_oor ? '0 : regs[ar_idx];
                RRESP  <= ar_oor ? RESP_DECERR : RESP_OKAY;
            end else if (r_hs) begin
                RVALID <= 1'b0;
            end
        end
    end

    // Register bank. Index 0 is never a write target, so it holds the ID.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs[0] <= C_ID_VALUE;
            for (int i = 1; i < C_REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            for (int i = 1; i < C_REG_COUNT; i++) begin
                if (aw_idx == C_IDX_BITS'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) begin
                            regs[i][8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < C_REG_COUNT; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - self-checking bench for axi4_lite_slave_regfile
module tb_axi4_lite_slave_regfile;

    localparam int          AW = 20;
    localparam int          N  = 16;
    localparam logic [31:0] ID = 32'h52460001;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [32*N-1:0] REG_OUT;
    logic            WR_EN;
    logic [3:0]      WR_INDEX;

    axi4_lite_slave_regfile dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .REG_OUT  (REG_OUT),
        .WR_EN    (WR_EN),
        .WR_INDEX (WR_INDEX)
    );

    always #5 CLK = ~CLK;

    int          nvec = 0;
    int          nfail = 0;
    int          wr_cnt = 0;
    logic [3:0]  wr_last = '0;
    logic [31:0] model [N];

    always @(negedge CLK) begin
        if (WR_EN) begin
            wr_cnt  = wr_cnt + 1;
            wr_last = WR_INDEX;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          mode;      // 0 W then AW, 1 together, 2 AW then W, 3 read only
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  bresp;
        int          pulses;
        logic [3:0]  widx;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regout(input string name);
        logic [32*N-1:0] e;
        for (int k = 0; k < N; k++) e[32*k +: 32] = model[k];
        nvec = nvec + 1;
        if (REG_OUT !== e) begin
            nfail = nfail + 1;
            $display("FAIL %s: REG_OUT=%h expected %h", name, REG_OUT, e);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic addr_data(input bit do_aw, input bit do_w, input logic [19:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bit aw_p, w_p, aw_h, w_h;
        int n;
        AWADDR = a; WDATA = d; WSTRB = s;
        aw_p = do_aw; w_p = do_w;
        AWVALID = do_aw; WVALID = do_w;
        n = 0;
        while ((aw_p || w_p) && n < 50) begin
            aw_h = AWVALID && AWREADY;
            w_h  = WVALID && WREADY;
            tick();
            n++;
            if (aw_h) begin aw_p = 0; AWVALID = 0; end
            if (w_h)  begin w_p = 0;  WVALID = 0;  end
        end
        AWVALID = 0; WVALID = 0;
        check("aw_w_handshake_done", {30'd0, aw_p, w_p}, 32'd0);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n;
        logic got;
        n = 0;
        BREADY = 1;
        while (!BVALID && n < 50) begin tick(); n++; end
        resp = BRESP;
        got  = BVALID;
        tick();
        BREADY = 0;
        check("bvalid_seen", got, 1);
    endtask

    task automatic do_write(input int mode, input logic [19:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        case (mode)
            0: begin addr_data(0, 1, a, d, s); addr_data(1, 0, a, d, s); end
            1: addr_data(1, 1, a, d, s);
            default: begin addr_data(1, 0, a, d, s); addr_data(0, 1, a, d, s); end
        endcase
        wait_b(resp);
    endtask

    task automatic do_read(input logic [19:0] a, output logic [31:0] data, output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1; n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        tick();
        ARVALID = 0;
        check("rvalid_one_cycle_after_ar", RVALID, 1);
        data = RDATA; resp = RRESP;
        RREADY = 1;
        tick();
        RREADY = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] hold_rdata;
        vec_t        v;
        int          c0;

        tbl[0]  = '{3, 20'h00000, 32'h0,        4'h0, 2'b00, 0, 4'd0,  32'h52460001, 2'b00};
        tbl[1]  = '{0, 20'h00008, 32'hDEADBEEF, 4'hF, 2'b00, 1, 4'd2,  32'hDEADBEEF, 2'b00};
        tbl[2]  = '{2, 20'h00008, 32'h0,        4'hF, 2'b00, 1, 4'd2,  32'h00000000, 2'b00};
        tbl[3]  = '{1, 20'h00008, 32'hDEADBEEF, 4'hF, 2'b00, 1, 4'd2,  32'hDEADBEEF, 2'b00};
        tbl[4]  = '{1, 20'h00008, 32'h0,        4'hF, 2'b00, 1, 4'd2,  32'h00000000, 2'b00};
        tbl[5]  = '{2, 20'h00008, 32'hDEADBEEF, 4'hF, 2'b00, 1, 4'd2,  32'hDEADBEEF, 2'b00};
        tbl[6]  = '{1, 20'h0000C, 32'h11223344, 4'hF, 2'b00, 1, 4'd3,  32'h11223344, 2'b00};
        tbl[7]  = '{0, 20'h0000C, 32'hAABBCCDD, 4'h5, 2'b00, 1, 4'd3,  32'h11BB33DD, 2'b00};
        tbl[8]  = '{2, 20'h0000E, 32'h0000EE00, 4'h2, 2'b00, 1, 4'd3,  32'h11BBEEDD, 2'b00};
        tbl[9]  = '{1, 20'h00000, 32'hFFFFFFFF, 4'hF, 2'b00, 0, 4'd0,  32'h52460001, 2'b00};
        tbl[10] = '{1, 20'h00040, 32'h12345678, 4'hF, 2'b11, 0, 4'd0,  32'h00000000, 2'b11};
        tbl[11] = '{0, 20'hFFFFC, 32'h12345678, 4'hF, 2'b11, 0, 4'd0,  32'h00000000, 2'b11};
        tbl[12] = '{1, 20'h0003C, 32'hCAFEF00D, 4'hF, 2'b00, 1, 4'd15, 32'hCAFEF00D, 2'b00};
        tbl[13] = '{2, 20'h0003C, 32'h12345678, 4'h0, 2'b00, 1, 4'd15, 32'hCAFEF00D, 2'b00};
        tbl[14] = '{1, 20'h00007, 32'h01020304, 4'h8, 2'b00, 1, 4'd1,  32'h01000000, 2'b00};
        tbl[15] = '{3, 20'h00014, 32'h0,        4'h0, 2'b00, 0, 4'd0,  32'h00000000, 2'b00};

        model[0] = ID;
        for (int k = 1; k < N; k++) model[k] = '0;

        nRST = 0;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARVALID = 0; RREADY = 0;
        repeat (3) tick();

        check("reset_valids_readys", {26'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_EN}, 32'd0);
        check("reset_rdata", RDATA, 32'd0);
        check("reset_resps_index", {24'd0, BRESP, RRESP, WR_INDEX}, 32'd0);
        check_regout("reset_reg_out");

        nRST = 1;
        check("ready_low_before_first_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick();
        check("ready_high_after_first_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            if (v.mode != 3) begin
                c0 = wr_cnt;
                do_write(v.mode, v.addr, v.wdata, v.wstrb, r);
                check($sformatf("v%0d_bresp", i), r, v.bresp);
                check($sformatf("v%0d_wr_en_pulses", i), wr_cnt - c0, v.pulses);
                if (v.pulses > 0) check($sformatf("v%0d_wr_index", i), wr_last, v.widx);
                if (v.rresp == 2'b00) model[v.addr[5:2]] = v.rdata;
                check_regout($sformatf("v%0d_reg_out", i));
            end
            do_read(v.addr, d, r);
            check($sformatf("v%0d_rdata", i), d, v.rdata);
            check($sformatf("v%0d_rresp", i), r, v.rresp);
        end

        // Backpressure: write and read responses held for 10 cycles.
        addr_data(1, 1, 20'h00010, 32'h55AA55AA, 4'hF);
        c0 = 0;
        while (!BVALID && c0 < 50) begin tick(); c0++; end
        ARADDR = 20'h00010; ARVALID = 1;
        c0 = 0;
        while (!ARREADY && c0 < 50) begin tick(); c0++; end
        tick();
        ARVALID = 0;
        hold_rdata = RDATA;
        check("bp_rdata_first", hold_rdata, 32'h55AA55AA);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_ctrl_c%0d", k),
                  {23'd0, BVALID, RVALID, AWREADY, WREADY, ARREADY, BRESP, RRESP},
                  {23'd0, 5'b11000, 4'b0000});
            check($sformatf("bp_rdata_c%0d", k), RDATA, hold_rdata);
            tick();
        end
        BREADY = 1; RREADY = 1;
        tick();
        BREADY = 0; RREADY = 0;
        check("bp_released", {27'd0, BVALID, RVALID, AWREADY, WREADY, ARREADY}, {27'd0, 5'b00111});
        model[4] = 32'h55AA55AA;
        check_regout("bp_reg_out");

        // Collision: read and write commit to reg 5 on the same edge.
        do_write(1, 20'h00014, 32'h1, 4'hF, r);
        model[5] = 32'h1;
        AWADDR = 20'h00014; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        check("coll_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        tick();
        AWVALID = 0; WVALID = 0;
        ARADDR = 20'h00014; ARVALID = 1;
        tick();
        ARVALID = 0;
        check("coll_b_r_valid", {30'd0, BVALID, RVALID}, 32'd3);
        check("coll_rdata_old", RDATA, 32'h1);
        model[5] = 32'h2;
        check_regout("coll_reg_out_new");
        RREADY = 1; BREADY = 1;
        tick();
        RREADY = 0; BREADY = 0;
        do_read(20'h00014, d, r);
        check("coll_readback_new", d, 32'h2);

        // Reset after AW, before W: transaction dropped.
        AWADDR = 20'h00014; AWVALID = 1;
        tick();
        AWVALID = 0;
        check("midrst_aw_latched", {30'd0, AWREADY, WREADY}, 32'd1);
        nRST = 0;
        #1;
        for (int k = 1; k < N; k++) model[k] = '0;
        check_regout("midrst_reg_out_cleared");
        check("midrst_bvalid_in_reset", BVALID, 0);
        tick();
        nRST = 1;
        WDATA = 32'h3; WSTRB = 4'hF; WVALID = 1;
        c0 = 0;
        for (int k = 0; k < 6; k++) begin
            if (BVALID) c0++;
            if (WVALID && WREADY) begin tick(); WVALID = 0; end
            else tick();
        end
        WVALID = 0;
        check("midrst_no_bvalid", c0, 0);
        do_read(20'h00014, d, r);
        check("midrst_reg5_zero", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
